seg7_serial_tx: RTL and testbench
=================================

// Module: seg7_serial_tx
// PURPOSE
//  Transmit side of the display path: takes the hex/point/blank-enable/raw words a test
//  or CPU source presents and serialises one 64-bit segment frame into the board's
//  chained 74HC595 shift registers for 8 seven-segment digits.
//  Single clock domain; sits between the display-data source and the board pins.
// PARAMETERS
//  CLK_DIV      2         clk cycles per half-period of seg_clk (>=1)
//  REFRESH_CYC  50000     idle cycles between auto frames (SEG_AUTO_REFRESH_EN only)
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  rst          in   1   asynchronous, active-high reset
//  refresh      in   1   start-frame request; sampled only in IDLE
//  mode         in   1   0 = text (hex decode), 1 = graphic (raw segments)
//  hexs         in   32  text mode: digit i = hexs[4i+3:4i]
//  dp           in   8   text mode: decimal point of digit i, 1 = lit
//  les          in   8   blink-enable of digit i
//  blink_phase  in   1   blink phase; digit blanked when les[i] & blink_phase
//  raw          in   64  graphic mode: frame bits, active-low, used verbatim
//  seg_clk      out  1   shift clock to 74HC595
//  seg_sout     out  1   serial data, MSB of frame first
//  seg_pen      out  1   latch/output-enable pulse (storage register clock)
//  seg_clrn     out  1   shift-register clear, active-low
//  busy         out  1   frame in progress (LOAD..LATCH)
//  done         out  1   one-cycle pulse when frame latched
// BEHAVIOUR
//  - Reset: seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0, busy=0, done=0, state IDLE,
//    bit counter 0, divider 0. seg_clrn goes 1 on the first clk edge after rst falls.
//  - FSM IDLE -> LOAD -> SHIFT -> LATCH -> DONE -> IDLE.
//  - IDLE: refresh=1 -> LOAD next cycle. refresh while not IDLE is ignored (not queued).
//  - LOAD (1 cycle): frame register captures all inputs; later input changes do not
//    affect the frame in flight. busy=1 from LOAD through LATCH.
//  - Text frame: byte i = frame[8i+7:8i] = {~dp[i], seg_n(hexs digit i)}, segments
//    {g,f,e,d,c,b,a} active-low; 0->7'h40, 8->7'h00, F->7'h0E (standard 16-glyph table).
//    If les[i] & blink_phase, byte i = 8'hFF. Graphic frame = raw.
//  - SHIFT: 64 bits, frame[63] first. Per bit: seg_sout set with seg_clk=0 for CLK_DIV
//    cycles, seg_clk=1 for CLK_DIV cycles (rising edge mid-bit, data stable). Counter
//    0..63; after bit 63's high phase seg_clk returns 0 and state -> LATCH.
//  - LATCH: seg_pen=1 for CLK_DIV cycles, seg_clk=0, then DONE.
//  - DONE: done=1 one cycle, busy=0; refresh high here is ignored; back to IDLE.
//  - Frame latency refresh->done = 1 + 1 + 128*CLK_DIV + CLK_DIV + 1 cycles
//    (CLK_DIV=2: 261).
//  - rst mid-frame: immediate abort to reset values; partial frame never latched
//    (seg_pen stays 0).
//  - Divider counts 0..CLK_DIV-1 and wraps; CLK_DIV=1 legal (seg_clk = clk/2).
// CONFIGURATION
//  - SEG_AUTO_REFRESH_EN defined: an internal counter starts a frame automatically after
//    REFRESH_CYC consecutive idle cycles. Counter clears on any frame start. refresh
//    still works and has priority.
//  - Undefined: frames start only on refresh; no counter is built.
// STRUCTURE
//  - Package seg7_pkg: state encoding (IDLE/LOAD/SHIFT/LATCH/DONE), FRAME_W=64,
//    hex-to-7seg table/function.
//  - One sub-module: seg7_hex_dec (4-bit hex -> 7-bit active-low segments), combinational,
//    instantiated 8x.
// TESTING
//  - Reset then mode=0, hexs=32'h0123_4567, dp=0, les=0, CLK_DIV=2 -> 64 bits captured on
//    seg_clk rises equal {FF? no: 8'hF8(7),8'h82(6),...,8'hC0(0)} per table; done at
//    cycle 261.
//  - mode=1, raw=64'hA5A5_0000_FFFF_1234 -> shifted bits equal raw MSB first; exactly one
//    seg_pen pulse of 2 cycles after bit 63.
//  - les=8'h01, blink_phase=1, dp=8'h01 -> last shifted byte 8'hFF; blink_phase=0 ->
//    last byte {0, seg(0)} = 8'h40.
//  - refresh pulsed again at cycle 50 and in DONE -> ignored; one done pulse only;
//    hexs changed mid-frame -> frame unchanged.
//  - rst asserted at bit 30 -> all outputs reset values same cycle, no seg_pen, next
//    refresh sends full 64 bits.
//  - SEG_AUTO_REFRESH_EN, REFRESH_CYC=10, refresh=0 -> frames start every 10 idle cycles;
//    without macro -> no frame ever starts.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit 74HC595 seven-segment transmit path:
// FSM state encoding, frame geometry and the active-low hex glyph table.
package seg7_pkg;

  localparam int FRAME_W = 64;
  localparam int DIGITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DONE
  } state_t;

  // Segments {g,f,e,d,c,b,a}, 0 = lit.
  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational 4-bit hex to 7-segment (active-low) decoder, one per digit.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex2seg(hex);

endmodule

// File: rtl/seg7_serial_tx.sv
// Serialises one 64-bit segment frame (MSB first) into chained 74HC595s, then pulses seg_pen.
// Optional SEG_AUTO_REFRESH_EN: start a frame by itself after REFRESH_CYC idle cycles.
module seg7_serial_tx
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 2
`ifdef SEG_AUTO_REFRESH_EN
  ,
  parameter int REFRESH_CYC = 50000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refresh,
  input  logic        mode,
  input  logic [31:0] hexs,
  input  logic [7:0]  dp,
  input  logic [7:0]  les,
  input  logic        blink_phase,
  input  logic [63:0] raw,
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        seg_pen,
  output logic        seg_clrn,
  output logic        busy,
  output logic        done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t               state;
  logic [FRAME_W-1:0]   frame;
  logic [FRAME_W-1:0]   frame_in;
  logic [5:0]           bit_cnt;
  logic [DIV_W-1:0]     div_cnt;
  logic                 div_last;
  logic                 start;
  logic                 auto_go;
  logic [DIGITS-1:0][6:0] seg_n;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    seg7_hex_dec u_dec (
      .hex (hexs[4*i +: 4]),
      .seg (seg_n[i])
    );
  end

  always_comb begin
    frame_in = raw;
    if (!mode) begin
      for (int i = 0; i < DIGITS; i++) begin
        frame_in[8*i +: 8] = (les[i] && blink_phase) ? 8'hFF : {~dp[i], seg_n[i]};
      end
    end
  end

`ifdef SEG_AUTO_REFRESH_EN
  localparam int RC_W = $clog2(REFRESH_CYC + 1);
  logic [RC_W-1:0] idle_cnt;

  assign auto_go = (state == ST_IDLE) && (idle_cnt == RC_W'(REFRESH_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state != ST_IDLE || refresh || auto_go) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign auto_go = 1'b0;
`endif

  assign start    = refresh || auto_go;
  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      frame    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      seg_clk  <= 1'b0;
      seg_sout <= 1'b0;
      seg_pen  <= 1'b0;
      seg_clrn <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      seg_clrn <= 1'b1;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          // Bit 63 goes straight to the pin; the register holds the remainder.
          frame    <= {frame_in[FRAME_W-2:0], 1'b0};
          seg_sout <= frame_in[FRAME_W-1];
          seg_clk  <= 1'b0;
          div_cnt  <= '0;
          bit_cnt  <= '0;
          state    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (!seg_clk) begin
              seg_clk <= 1'b1;
            end else begin
              seg_clk <= 1'b0;
              if (bit_cnt == 6'd63) begin
                bit_cnt  <= '0;
                seg_sout <= 1'b0;
                seg_pen  <= 1'b1;
                state    <= ST_LATCH;
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                seg_sout <= frame[FRAME_W-1];
                frame    <= {frame[FRAME_W-2:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_LATCH: begin
          if (div_last) begin
            div_cnt <= '0;
            seg_pen <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_serial_tx.sv
// Randomised scoreboard bench for seg7_serial_tx: a monitor rebuilds each frame from
// seg_clk rises and compares it, on seg_pen, with the reference-model frame queued at issue.
module tb_seg7_serial_tx;

  localparam int CLK_DIV     = 2;
  localparam int REFRESH_CYC = 10;
  localparam int LAT_CYC     = 1 + 1 + 128 * CLK_DIV + CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        refresh = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] hexs = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  les = '0;
  logic        blink_phase = 1'b0;
  logic [63:0] raw = '0;
  logic        seg_clk, seg_sout, seg_pen, seg_clrn, busy, done;

  int tests = 0;
  int fails = 0;
  int bits_n = 0;
  logic [63:0] exp_q[$];

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_serial_tx #(
    .CLK_DIV(CLK_DIV)
`ifdef SEG_AUTO_REFRESH_EN
    , .REFRESH_CYC(REFRESH_CYC)
`endif
  ) dut (
    .clk(clk), .rst(rst), .refresh(refresh), .mode(mode), .hexs(hexs), .dp(dp),
    .les(les), .blink_phase(blink_phase), .raw(raw), .seg_clk(seg_clk),
    .seg_sout(seg_sout), .seg_pen(seg_pen), .seg_clrn(seg_clrn), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_frame(input logic m, input logic [31:0] h,
      input logic [7:0] d, input logic [7:0] l, input logic bp, input logic [63:0] r);
    logic [63:0] f;
    if (m) return r;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      int dig;
      dig = int'((h >> (4 * i)) & 32'hF);
      f[8*i +: 8] = (l[i] && bp) ? 8'hFF : {~d[i], glyph[dig]};
    end
    return f;
  endfunction

  // Monitor: collect bits on seg_clk rises, compare on seg_pen rise, measure pen width.
  initial begin
    logic        prev_clk, prev_pen;
    logic [63:0] got, exp;
    int          pen_w;
    prev_clk = 1'b0; prev_pen = 1'b0; pen_w = 0; got = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bits_n = 0; prev_clk = 1'b0; prev_pen = 1'b0; pen_w = 0;
      end else begin
        if (seg_clk && !prev_clk) begin
          got = {got[62:0], seg_sout};
          bits_n++;
        end
        if (seg_pen && !prev_pen) begin
          check("bits_before_latch", 64'(bits_n), 64'd64);
          if (exp_q.size() == 0) begin
            check("unexpected_latch", 64'd1, 64'd0);
          end else begin
            exp = exp_q.pop_front();
            check("frame_data", got, exp);
          end
          bits_n = 0;
        end
        if (seg_pen) pen_w++;
        if (!seg_pen && prev_pen) begin
          check("seg_pen_width", 64'(pen_w), 64'(CLK_DIV));
          pen_w = 0;
        end
        prev_clk = seg_clk;
        prev_pen = seg_pen;
      end
    end
  end

  task automatic send(input logic m, input logic [31:0] h, input logic [7:0] d,
      input logic [7:0] l, input logic bp, input logic [63:0] r, input logic [63:0] exp,
      input bit disturb);
    int n;
    bit seen;
    @(negedge clk);
    mode = m; hexs = h; dp = d; les = l; blink_phase = bp; raw = r; refresh = 1'b1;
    exp_q.push_back(exp);
    n = 0; seen = 0;
    while (!seen && n < 2000) begin
      @(posedge clk); n++; #1;
      if (n == 1) begin
        refresh = 1'b0;
        check("busy_in_load", busy, 1'b1);
      end
      if (disturb && n == 50) begin
        refresh = 1'b1; hexs = ~h; dp = ~d; raw = ~r; blink_phase = ~bp;
      end
      if (disturb && n == 51) refresh = 1'b0;
      if (done) seen = 1;
    end
    // done is high in the last of the LAT_CYC cycles that begin with the refresh cycle
    check("done_latency", 64'(n), 64'(LAT_CYC - 1));
    if (disturb) refresh = 1'b1;
    @(posedge clk); #1;
    refresh = 1'b0;
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    if (disturb) begin
      repeat (20) @(posedge clk);
      #1 check("refresh_ignored", busy, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg_clk"}, seg_clk, 1'b0);
    check({tag, "_seg_sout"}, seg_sout, 1'b0);
    check({tag, "_seg_pen"}, seg_pen, 1'b0);
    check({tag, "_seg_clrn"}, seg_clrn, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    logic [31:0] h;
    logic [63:0] r;
    logic [7:0]  d, l;
    logic        m, bp;
    int          n;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 check("clrn_held_until_edge", seg_clrn, 1'b0);
    @(posedge clk); #1;
    check("clrn_after_reset", seg_clrn, 1'b1);

`ifdef SEG_AUTO_REFRESH_EN
    // Inputs fixed; frames start on their own after each idle stretch.
    hexs = 32'hDEAD_BEEF; dp = 8'h5A;
    for (int k = 0; k < 3; k++) exp_q.push_back(model_frame(1'b0, hexs, dp, 8'h00, 1'b0, raw));
    for (int k = 0; k < 3; k++) begin
      int idle;
      n = 0;
      while (!done && n < 2000) begin @(posedge clk); n++; #1; end
      check("auto_done_seen", done, 1'b1);
      if (k < 2) begin
        idle = 0;
        n = 0;
        while (n < 100) begin
          @(posedge clk); n++; #1;
          if (busy) break;
          idle++;
        end
        check("auto_idle_gap", 64'(idle), 64'(REFRESH_CYC));
      end
    end
`else
    send(1'b0, 32'h0123_4567, 8'h00, 8'h00, 1'b0, '0, 64'hC0F9_A4B0_9992_82F8, 1'b0);
    send(1'b1, '0, '0, '0, 1'b0, 64'hA5A5_0000_FFFF_1234, 64'hA5A5_0000_FFFF_1234, 1'b0);
    send(1'b0, 32'h89AB_CDE0, 8'h01, 8'h01, 1'b1, '0,
         model_frame(1'b0, 32'h89AB_CDE0, 8'h01, 8'h01, 1'b1, '0), 1'b0);
    send(1'b0, 32'h89AB_CDE0, 8'h01, 8'h01, 1'b0, '0,
         model_frame(1'b0, 32'h89AB_CDE0, 8'h01, 8'h01, 1'b0, '0), 1'b0);
    h = 32'h3C5A_F019; d = 8'h96;
    send(1'b0, h, d, 8'h00, 1'b0, '0, model_frame(1'b0, h, d, 8'h00, 1'b0, '0), 1'b1);

    for (int k = 0; k < 6; k++) begin
      m = 1'($urandom_range(0, 1)); h = $urandom; d = 8'($urandom); l = 8'($urandom);
      bp = 1'($urandom_range(0, 1)); r = {$urandom, $urandom};
      send(m, h, d, l, bp, r, model_frame(m, h, d, l, bp, r), 1'b0);
    end

    // Abort mid-frame with rst: outputs reset at once and nothing gets latched.
    @(negedge clk);
    mode = 1'b0; hexs = $urandom; dp = 8'($urandom); les = 8'h00; refresh = 1'b1;
    exp_q.push_back(model_frame(1'b0, hexs, dp, les, 1'b0, raw));
    @(posedge clk); #1 refresh = 1'b0;
    n = 0;
    while (bits_n < 30 && n < 1000) begin @(posedge clk); n++; #2; end
    check("abort_reached_bit30", 64'(bits_n), 64'd30);
    rst = 1'b1;
    #1 check_reset_outputs("abort");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1 check("abort_no_restart", busy, 1'b0);
    r = {$urandom, $urandom};
    send(1'b1, '0, '0, '0, 1'b0, r, r, 1'b0);

    // Without auto-refresh nothing starts while refresh stays low.
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (busy || done) n++;
    end
    check("no_auto_frame", 64'(n), 64'd0);
`endif

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
